// File: rtl/sar_readout_pkg.sv
// sar_readout_pkg
// Shared types for the SAR frame readout sequencer.
//   readout_state_t : sequencer FSM state encoding
//   pixel_word_t    : captured output word (code, row/col tag, timeout flag)
// The word struct is sized for the largest supported configuration; the top
// zero-extends into it and slices its own widths back out.
package sar_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONVERT,
    ST_RELEASE,
    ST_OUTPUT
  } readout_state_t;

  // Upper bounds for RESOLUTION and the row/column address widths.
  localparam int PIX_DATA_W = 16;
  localparam int PIX_ADDR_W = 8;

  typedef struct packed {
    logic [PIX_DATA_W-1:0] data;
    logic [PIX_ADDR_W-1:0] row;
    logic [PIX_ADDR_W-1:0] col;
    logic                  err;
  } pixel_word_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Address width that stays at least one bit for a single row/column.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_readout_ctrl_timer.sv
// readout_timer
// Loadable down-counter shared by the settle delay and the conversion timeout.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   load, load_value: load the counter (takes priority over dec)
//   dec             : decrement by one, saturating at zero
//   expired         : counter is at zero (terminal count)
module readout_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/sar_readout_ctrl.sv
// sar_readout_ctrl
// Frame readout sequencer: scans the pixel array row/column address, lets the
// address settle, runs one SAR conversion per pixel, and presents each code
// tagged with its address on a valid/ready stream.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   start                 : begin a frame (only honoured when idle)
//   row_sel, col_sel      : pixel address to the array decoders
//   adc_enable            : conversion enable to the ADC (level)
//   adc_done, adc_code    : conversion complete and result from the ADC
//   out_valid, out_ready  : output stream handshake
//   out_data, out_row,
//   out_col, out_err      : output word (err = conversion timed out, data 0)
//   busy                  : frame in progress
//   frame_done            : one-cycle pulse after the last word is accepted
//   timeout_err           : sticky timeout flag, cleared by the next start
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_SETTLE  | address held, enable low, settle timer running
// ST_CONVERT | enable high, waiting for done or timeout
// ST_RELEASE | enable low for one cycle so the ADC resets its SAR
// ST_OUTPUT  | word presented, waiting for out_ready
module sar_readout_ctrl
  import sar_readout_pkg::*;
#(
  parameter int RESOLUTION     = 8,
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic [addr_width(ROWS)-1:0] row_sel,
  output logic [addr_width(COLS)-1:0] col_sel,
  output logic                        adc_enable,
  input  logic                        adc_done,
  input  logic [RESOLUTION-1:0]       adc_code,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RESOLUTION-1:0]       out_data,
  output logic [addr_width(ROWS)-1:0] out_row,
  output logic [addr_width(COLS)-1:0] out_col,
  output logic                        out_err,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        timeout_err
);

  localparam int RW = addr_width(ROWS);
  localparam int CW = addr_width(COLS);
  localparam int TW = $clog2(max_int(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);

  // Timer counts down to zero and the state exits on the expired cycle, so
  // loading N-1 gives a state duration of exactly N cycles.
  localparam logic [TW-1:0] SETTLE_LOAD  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

  readout_state_t  state_q, state_nxt;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  pixel_word_t     out_q;
  logic            timeout_err_q;
  logic            frame_done_q;

  logic            timer_load;
  logic [TW-1:0]   timer_value;
  logic            timer_dec;
  logic            timer_expired;
  logic            frame_begin;
  logic            cap_code;
  logic            cap_timeout;
  logic            advance;
  logic            frame_end;
  logic            is_last;
  logic            unused_word;

  readout_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .expired    (timer_expired)
  );

  assign is_last = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    timer_load  = 1'b0;
    timer_value = '0;
    timer_dec   = 1'b0;
    frame_begin = 1'b0;
    cap_code    = 1'b0;
    cap_timeout = 1'b0;
    advance     = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_nxt   = ST_SETTLE;
          timer_load  = 1'b1;
          timer_value = SETTLE_LOAD;
          frame_begin = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_expired) begin
          state_nxt   = ST_CONVERT;
          timer_load  = 1'b1;
          timer_value = TIMEOUT_LOAD;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_CONVERT: begin
        // done has priority over a timeout landing on the same edge
        if (adc_done) begin
          state_nxt = ST_RELEASE;
          cap_code  = 1'b1;
        end else if (timer_expired) begin
          state_nxt   = ST_RELEASE;
          cap_timeout = 1'b1;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          if (is_last) begin
            state_nxt = ST_IDLE;
            frame_end = 1'b1;
          end else begin
            state_nxt   = ST_SETTLE;
            advance     = 1'b1;
            timer_load  = 1'b1;
            timer_value = SETTLE_LOAD;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q         <= '0;
      col_q         <= '0;
      out_q         <= '0;
      timeout_err_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= frame_end;

      if (frame_begin) begin
        row_q         <= '0;
        col_q         <= '0;
        timeout_err_q <= 1'b0;
      end else if (advance) begin
        if (col_q == CW'(COLS - 1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end

      if (cap_code) begin
        out_q.data <= PIX_DATA_W'(adc_code);
        out_q.row  <= PIX_ADDR_W'(row_q);
        out_q.col  <= PIX_ADDR_W'(col_q);
        out_q.err  <= 1'b0;
      end else if (cap_timeout) begin
        out_q.data    <= '0;
        out_q.row     <= PIX_ADDR_W'(row_q);
        out_q.col     <= PIX_ADDR_W'(col_q);
        out_q.err     <= 1'b1;
        timeout_err_q <= 1'b1;
      end
    end
  end

  // Enable, valid and busy decode straight from the state register so an
  // asynchronous reset drops them immediately.
  assign adc_enable  = (state_q == ST_CONVERT);
  assign out_valid   = (state_q == ST_OUTPUT);
  assign busy        = (state_q != ST_IDLE);
  assign row_sel     = row_q;
  assign col_sel     = col_q;
  assign out_data    = out_q.data[RESOLUTION-1:0];
  assign out_row     = out_q.row[RW-1:0];
  assign out_col     = out_q.col[CW-1:0];
  assign out_err     = out_q.err;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;

  // Padding bits of the word struct above the configured widths.
  assign unused_word = ^out_q;

endmodule

// File: tb/tb_sar_readout_ctrl.sv
module tb_sar_readout_ctrl;

  localparam int RES    = 8;
  localparam int ROWS   = 2;
  localparam int COLS   = 3;
  localparam int SETTLE = 2;
  localparam int TMO    = 64;
  localparam int NPIX   = ROWS * COLS;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           out_ready = 1'b0;
  logic [0:0]     row_sel, out_row;
  logic [1:0]     col_sel, out_col;
  logic           adc_enable, adc_done;
  logic [RES-1:0] adc_code, out_data;
  logic           out_valid, out_err, busy, frame_done, timeout_err;

  // ADC model: done rises in the Nth cycle of enable (never when lat == 0),
  // or is forced high regardless of enable.
  int             en_cnt;
  int             cur_lat = 1;
  logic [RES-1:0] cur_code = '0;
  logic           force_done = 1'b0;

  int checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int pix = 0;
  bit exp_terr = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) en_cnt <= 0;
    else        en_cnt <= adc_enable ? en_cnt + 1 : 0;
  end

  assign adc_done = force_done || (adc_enable && (cur_lat > 0) && (en_cnt >= cur_lat - 1));
  assign adc_code = cur_code;

  sar_readout_ctrl #(
    .RESOLUTION     (RES),
    .ROWS           (ROWS),
    .COLS           (COLS),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .row_sel     (row_sel),
    .col_sel     (col_sel),
    .adc_enable  (adc_enable),
    .adc_done    (adc_done),
    .adc_code    (adc_code),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_err     (out_err),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accepted start.
  task automatic start_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pix = 0;
    exp_terr = 1'b0;
    check("start_busy", busy, 1);
    check("start_terr_clr", timeout_err, 0);
    check("start_fdone", frame_done, 0);
  endtask

  // Runs one pixel from its first SETTLE cycle to the handshake.
  // lat: done after lat enable cycles (0 = never); stuck: done held high.
  task automatic do_pixel(input int lat, input int stall, input bit stuck);
    int n, en_seen, l_exp, er, ec;
    logic [RES-1:0] code, exp_data;
    bit exp_err;
    er = pix / COLS;
    ec = pix % COLS;
    code = RES'($urandom);
    cur_code = code;
    cur_lat = lat;
    force_done = stuck;
    exp_err = !stuck && (lat == 0);
    l_exp = stuck ? 1 : (lat == 0 ? TMO : lat);
    exp_data = exp_err ? '0 : code;
    check("addr_row", row_sel, er);
    check("addr_col", col_sel, ec);
    n = 0;
    en_seen = 0;
    while (!out_valid && n < 300) begin
      if (adc_enable) en_seen++;
      @(negedge clk);
      n++;
    end
    force_done = 1'b0;
    check("wait_cycles", n, SETTLE + l_exp + 1);
    check("enable_cycles", en_seen, l_exp);
    if (exp_err) exp_terr = 1'b1;
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, exp_data);
      check("stall_tag", {out_row, out_col}, {er[0], ec[1:0]});
      check("stall_enable", adc_enable, 0);
      check("stall_addr", {row_sel, col_sel}, {er[0], ec[1:0]});
      @(negedge clk);
    end
    check("word_valid", out_valid, 1);
    check("word_data", out_data, exp_data);
    check("word_row", out_row, er);
    check("word_col", out_col, ec);
    check("word_err", out_err, exp_err);
    check("timeout_err", timeout_err, exp_terr);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    pix++;
    if (pix == NPIX) begin
      check("frame_done_pulse", frame_done, 1);
      check("frame_end_busy", busy, 0);
    end else begin
      check("mid_frame_done", frame_done, 0);
      check("after_hs_valid", out_valid, 0);
      check("after_hs_busy", busy, 1);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_enable", adc_enable, 0);
    check("rst_valid", out_valid, 0);
    check("rst_word", {out_data, out_row, out_col, out_err}, 0);
    check("rst_addr", {row_sel, col_sel}, 0);
    check("rst_flags", {frame_done, timeout_err}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Frame A: random latencies, ready high.
    start_frame();
    for (int p = 0; p < NPIX; p++) do_pixel($urandom_range(1, 12), 0, 1'b0);
    @(negedge clk);
    check("fdone_single", frame_done, 0);
    check("idle_busy", busy, 0);

    // Frame B: backpressure, 5 stall cycles on pixel 1, random elsewhere.
    start_frame();
    for (int p = 0; p < NPIX; p++)
      do_pixel($urandom_range(1, 10), (p == 1) ? 5 : $urandom_range(0, 3), 1'b0);
    @(negedge clk);

    // Frame C: pixel 1 never completes; the scan continues.
    start_frame();
    for (int p = 0; p < NPIX; p++) do_pixel((p == 1) ? 0 : $urandom_range(1, 8), 0, 1'b0);
    repeat (3) @(negedge clk);
    check("terr_sticky_idle", timeout_err, 1);

    // Frame D: next start clears the flag; done stuck high on pixel 0;
    // start held high mid-frame is ignored; restart in frame_done cycle.
    start_frame();
    do_pixel(0, 0, 1'b1);
    start = 1'b1;
    do_pixel($urandom_range(1, 6), 1, 1'b0);
    start = 1'b0;
    for (int p = 2; p < NPIX; p++) do_pixel($urandom_range(1, 6), 0, 1'b0);
    start_frame();
    check("restart_addr", {row_sel, col_sel}, 0);

    // Frame E: asynchronous reset during conversion of pixel (1,0).
    for (int p = 0; p < COLS; p++) do_pixel($urandom_range(1, 6), 0, 1'b0);
    cur_lat = 30;
    check("rst_pix_addr", {row_sel, col_sel}, {1'b1, 2'd0});
    n = 0;
    while (!adc_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_convert", adc_enable, 1);
    #2 reset = 1'b0;
    #1;
    check("async_enable", adc_enable, 0);
    check("async_valid", out_valid, 0);
    check("async_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    start_frame();
    for (int p = 0; p < NPIX; p++) do_pixel($urandom_range(1, 12), $urandom_range(0, 2), 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, checks);
    $finish;
  end

endmodule
